// File: rtl/divc_if.sv
// Operand/result handshake bundle for the divc complex divider.
// The master side supplies operands and accepts results; the slave side is the divider.
interface divc_if #(
  parameter int NW = 32,
  parameter int DW = 16
);
  localparam int QW = NW + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [NW-1:0] n_re;
  logic signed [NW-1:0] n_im;
  logic signed [DW-1:0] d_re;
  logic signed [DW-1:0] d_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [QW-1:0] q_re;
  logic signed [QW-1:0] q_im;
  logic                 div_zero;

  modport master (
    output in_valid, n_re, n_im, d_re, d_im, out_ready,
    input  in_ready, out_valid, q_re, q_im, div_zero
  );

  modport slave (
    input  in_valid, n_re, n_im, d_re, d_im, out_ready,
    output in_ready, out_valid, q_re, q_im, div_zero
  );
endinterface

// File: rtl/divc.sv
// Sequential complex integer divider: q = n / d = n*conj(d) / |d|^2.
// Two restoring dividers (real and imaginary) share one denominator and run in
// lock step, one quotient bit per cycle, MSB first. One operation in flight.
module divc #(
  parameter int NW = 32,
  parameter int DW = 16
) (
  input  logic clk,
  input  logic rst,
  divc_if.slave bus
);
  localparam int MW   = NW + DW;
  localparam int QW   = NW + 1;
  localparam int DENW = 2 * DW;
  localparam int CW   = $clog2(MW);

  typedef enum logic [2:0] {IDLE, PREP, DIV, SIGN, DONE} state_t;

  state_t               state;
  logic signed [NW-1:0] n_re_r, n_im_r;
  logic signed [DW-1:0] d_re_r, d_im_r;
  logic [MW-1:0]        mag_re, mag_im;
  logic                 neg_re, neg_im;
  logic [DENW-1:0]      den;
  logic [DENW-1:0]      rem_re, rem_im;
  logic [CW-1:0]        cnt;
  logic                 dz_r;
  logic signed [QW-1:0] q_re_r, q_im_r;
  logic                 in_ready_r, out_valid_r, div_zero_r;

  logic signed [MW-1:0]   p_rr, p_ii, p_ir, p_ri;
  logic signed [MW:0]     num_re_c, num_im_c, neg_num_re, neg_num_im;
  logic [MW-1:0]          abs_re_c, abs_im_c;
  logic signed [DENW-1:0] sq_re, sq_im;
  logic [DENW-1:0]        den_c;

  // Numerator n*conj(d), its per-component magnitude, and |d|^2 from the registered operands.
  always_comb begin
    p_rr       = MW'(n_re_r) * MW'(d_re_r);
    p_ii       = MW'(n_im_r) * MW'(d_im_r);
    p_ir       = MW'(n_im_r) * MW'(d_re_r);
    p_ri       = MW'(n_re_r) * MW'(d_im_r);
    num_re_c   = (MW+1)'(p_rr) + (MW+1)'(p_ii);
    num_im_c   = (MW+1)'(p_ir) - (MW+1)'(p_ri);
    neg_num_re = -num_re_c;
    neg_num_im = -num_im_c;
    abs_re_c   = num_re_c[MW] ? neg_num_re[MW-1:0] : num_re_c[MW-1:0];
    abs_im_c   = num_im_c[MW] ? neg_num_im[MW-1:0] : num_im_c[MW-1:0];
    sq_re      = DENW'(d_re_r) * DENW'(d_re_r);
    sq_im      = DENW'(d_im_r) * DENW'(d_im_r);
    den_c      = $unsigned(sq_re) + $unsigned(sq_im);
  end

  logic [DENW:0]   trial_re, trial_im;
  logic            ge_re, ge_im;
  logic [DENW-1:0] rem_re_nxt, rem_im_nxt;

  // One restoring step: shift the next dividend bit into the remainder and subtract den if it fits.
  always_comb begin
    trial_re   = {rem_re, mag_re[MW-1]};
    trial_im   = {rem_im, mag_im[MW-1]};
    ge_re      = trial_re >= {1'b0, den};
    ge_im      = trial_im >= {1'b0, den};
    rem_re_nxt = ge_re ? DENW'(trial_re - {1'b0, den}) : trial_re[DENW-1:0];
    rem_im_nxt = ge_im ? DENW'(trial_im - {1'b0, den}) : trial_im[DENW-1:0];
  end

  // Control FSM and datapath registers; mag_* is a shift register that turns into the quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_re_r      <= '0;
      q_im_r      <= '0;
      div_zero_r  <= 1'b0;
      n_re_r      <= '0;
      n_im_r      <= '0;
      d_re_r      <= '0;
      d_im_r      <= '0;
      mag_re      <= '0;
      mag_im      <= '0;
      neg_re      <= 1'b0;
      neg_im      <= 1'b0;
      den         <= '0;
      rem_re      <= '0;
      rem_im      <= '0;
      cnt         <= '0;
      dz_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            n_re_r     <= bus.n_re;
            n_im_r     <= bus.n_im;
            d_re_r     <= bus.d_re;
            d_im_r     <= bus.d_im;
            in_ready_r <= 1'b0;
            state      <= PREP;
          end
        end
        PREP: begin
          neg_re <= num_re_c[MW];
          neg_im <= num_im_c[MW];
          den    <= den_c;
          rem_re <= '0;
          rem_im <= '0;
          cnt    <= CW'(MW - 1);
          if (den_c == '0) begin
            // A zero divisor skips the iterations; SIGN then loads a zero quotient.
            mag_re <= '0;
            mag_im <= '0;
            dz_r   <= 1'b1;
            state  <= SIGN;
          end else begin
            mag_re <= abs_re_c;
            mag_im <= abs_im_c;
            dz_r   <= 1'b0;
            state  <= DIV;
          end
        end
        DIV: begin
          rem_re <= rem_re_nxt;
          rem_im <= rem_im_nxt;
          mag_re <= {mag_re[MW-2:0], ge_re};
          mag_im <= {mag_im[MW-2:0], ge_im};
          if (cnt == '0) begin
            state <= SIGN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SIGN: begin
          q_re_r      <= neg_re ? QW'(-mag_re[QW-1:0]) : mag_re[QW-1:0];
          q_im_r      <= neg_im ? QW'(-mag_im[QW-1:0]) : mag_im[QW-1:0];
          div_zero_r  <= dz_r;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.q_re      = q_re_r;
  assign bus.q_im      = q_im_r;
  assign bus.div_zero  = div_zero_r;
endmodule

// File: tb/tb_divc.sv
// Testbench for divc: expected quotients come from a 64-bit integer model and are
// queued when an operation is issued, then popped when the divider presents a result.
module tb_divc;
  localparam int NW = 32;
  localparam int DW = 16;
  localparam int MW = NW + DW;
  localparam int QW = NW + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  divc_if #(.NW(NW), .DW(DW)) bus ();

  divc #(.NW(NW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [QW-1:0] q_re;
    logic signed [QW-1:0] q_im;
    logic                 dz;
    int                   lat;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  function automatic exp_t model(int nr, int ni, shortint dr, shortint di);
    longint a, b, den;
    exp_t   e;
    den = longint'(dr) * dr + longint'(di) * di;
    if (den == 0) begin
      e.q_re = '0;
      e.q_im = '0;
      e.dz   = 1'b1;
      e.lat  = 2;
    end else begin
      a      = longint'(nr) * dr + longint'(ni) * di;
      b      = longint'(ni) * dr - longint'(nr) * di;
      e.q_re = QW'(a / den);
      e.q_im = QW'(b / den);
      e.dz   = 1'b0;
      e.lat  = MW + 2;
    end
    return e;
  endfunction

  task automatic send_op(input int nr, input int ni, input shortint dr, input shortint di);
    int t;
    t = 0;
    sb.push_back(model(nr, ni, dr, di));
    bus.in_valid = 1'b1;
    bus.n_re = nr;
    bus.n_im = ni;
    bus.d_re = dr;
    bus.d_im = di;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    n_total++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL accept_wait in_ready=%0b required=1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.n_re = $urandom;
    bus.n_im = $urandom;
    bus.d_re = 16'($urandom);
    bus.d_im = 16'($urandom);
  endtask

  task automatic wait_result(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total += 4;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset in_ready got=%0b exp=1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset out_valid got=%0b exp=0", bus.out_valid); end
    if (bus.q_re !== '0 || bus.q_im !== '0) begin n_bad++; $display("[TB] FAIL reset q got=(%0d,%0d) exp=(0,0)", bus.q_re, bus.q_im); end
    if (bus.div_zero !== 1'b0) begin n_bad++; $display("[TB] FAIL reset div_zero got=%0b exp=0", bus.div_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int   lat;
    exp_t e;
    send_op(10, 5, 1, 2);
    wait_result(lat);
    e = sb.pop_front();
    n_total += 4;
    if (lat != 50) begin n_bad++; $display("[TB] FAIL basic latency got=%0d exp=50", lat); end
    if (bus.q_re !== 33'sd4) begin n_bad++; $display("[TB] FAIL basic q_re got=%0d exp=4", bus.q_re); end
    if (bus.q_im !== e.q_im) begin n_bad++; $display("[TB] FAIL basic q_im got=%0d exp=%0d", bus.q_im, e.q_im); end
    if (bus.div_zero !== 1'b0) begin n_bad++; $display("[TB] FAIL basic div_zero got=%0b exp=0", bus.div_zero); end
    ack();
    n_total++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL basic in_ready_after_ack got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_truncation();
    int   lat;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      send_op(i == 0 ? 7 : -7, 0, 2, 0);
      wait_result(lat);
      e = sb.pop_front();
      n_total += 3;
      if (lat != e.lat) begin n_bad++; $display("[TB] FAIL trunc%0d latency got=%0d exp=%0d", i, lat, e.lat); end
      if (bus.q_re !== e.q_re) begin n_bad++; $display("[TB] FAIL trunc%0d q_re got=%0d exp=%0d", i, bus.q_re, e.q_re); end
      if (bus.q_im !== e.q_im) begin n_bad++; $display("[TB] FAIL trunc%0d q_im got=%0d exp=%0d", i, bus.q_im, e.q_im); end
      ack();
    end
  endtask

  task automatic test_div_zero();
    int   lat;
    exp_t e;
    send_op(123, -45, 0, 0);
    wait_result(lat);
    e = sb.pop_front();
    n_total += 4;
    if (lat != 2) begin n_bad++; $display("[TB] FAIL divzero latency got=%0d exp=2", lat); end
    if (bus.q_re !== e.q_re) begin n_bad++; $display("[TB] FAIL divzero q_re got=%0d exp=%0d", bus.q_re, e.q_re); end
    if (bus.q_im !== e.q_im) begin n_bad++; $display("[TB] FAIL divzero q_im got=%0d exp=%0d", bus.q_im, e.q_im); end
    if (bus.div_zero !== 1'b1) begin n_bad++; $display("[TB] FAIL divzero div_zero got=%0b exp=1", bus.div_zero); end
    ack();
  endtask

  task automatic test_extreme();
    int   lat;
    exp_t e;
    send_op(32'sh8000_0000, 0, -16'sd32768, -16'sd32768);
    wait_result(lat);
    e = sb.pop_front();
    n_total += 3;
    if (bus.q_re !== 33'sd32768) begin n_bad++; $display("[TB] FAIL extreme q_re got=%0d exp=32768", bus.q_re); end
    if (bus.q_im !== e.q_im) begin n_bad++; $display("[TB] FAIL extreme q_im got=%0d exp=%0d", bus.q_im, e.q_im); end
    if (bus.div_zero !== 1'b0) begin n_bad++; $display("[TB] FAIL extreme div_zero got=%0b exp=0", bus.div_zero); end
    ack();
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    send_op(7, 0, 2, 0);
    wait_result(lat);
    e = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_total += 3;
      if (bus.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL hold%0d out_valid got=%0b exp=1", c, bus.out_valid); end
      if (bus.q_re !== e.q_re || bus.q_im !== e.q_im || bus.div_zero !== e.dz) begin
        n_bad++;
        $display("[TB] FAIL hold%0d result got=(%0d,%0d,%0b) exp=(%0d,%0d,%0b)", c, bus.q_re, bus.q_im, bus.div_zero, e.q_re, e.q_im, e.dz);
      end
      if (bus.in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL hold%0d in_ready got=%0b exp=0", c, bus.in_ready); end
    end
    ack();
    n_total += 2;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL release in_ready got=%0b exp=1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL release out_valid got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    int   lat;
    exp_t e;
    send_op(10, 5, 1, 2);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    n_total += 3;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL midreset in_ready got=%0b exp=1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset out_valid got=%0b exp=0", bus.out_valid); end
    if (bus.q_re !== '0 || bus.q_im !== '0) begin n_bad++; $display("[TB] FAIL midreset q got=(%0d,%0d) exp=(0,0)", bus.q_re, bus.q_im); end
    send_op(10, 5, 1, 2);
    wait_result(lat);
    e = sb.pop_front();
    n_total += 3;
    if (lat != e.lat) begin n_bad++; $display("[TB] FAIL after_reset latency got=%0d exp=%0d", lat, e.lat); end
    if (bus.q_re !== 33'sd4) begin n_bad++; $display("[TB] FAIL after_reset q_re got=%0d exp=4", bus.q_re); end
    if (bus.q_im !== -33'sd3) begin n_bad++; $display("[TB] FAIL after_reset q_im got=%0d exp=-3", bus.q_im); end
    ack();
  endtask

  task automatic test_random();
    int      lat, nr, ni;
    shortint dr, di;
    exp_t    e;
    for (int i = 0; i < 8; i++) begin
      nr = $urandom;
      ni = $urandom;
      if (i % 2 == 1) begin
        dr = shortint'($urandom_range(0, 6)) - 16'sd3;
        di = shortint'($urandom_range(0, 6)) - 16'sd3;
      end else begin
        dr = shortint'($urandom);
        di = shortint'($urandom);
      end
      send_op(nr, ni, dr, di);
      wait_result(lat);
      e = sb.pop_front();
      n_total += 4;
      if (lat != e.lat) begin n_bad++; $display("[TB] FAIL rand%0d latency got=%0d exp=%0d", i, lat, e.lat); end
      if (bus.q_re !== e.q_re) begin n_bad++; $display("[TB] FAIL rand%0d q_re got=%0d exp=%0d", i, bus.q_re, e.q_re); end
      if (bus.q_im !== e.q_im) begin n_bad++; $display("[TB] FAIL rand%0d q_im got=%0d exp=%0d", i, bus.q_im, e.q_im); end
      if (bus.div_zero !== e.dz) begin n_bad++; $display("[TB] FAIL rand%0d div_zero got=%0b exp=%0b", i, bus.div_zero, e.dz); end
      ack();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.n_re = '0;
    bus.n_im = '0;
    bus.d_re = '0;
    bus.d_im = '0;
    test_reset();
    test_basic();
    test_truncation();
    test_div_zero();
    test_extreme();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
